// File: rtl/btn_debounce.sv
// Per-channel button conditioner: 2-flop synchroniser, debounce FSM, held level, press/release pulses.
// Optional long-press pulse is built only when BTN_DEBOUNCE_LONG_PRESS_EN is defined.
module btn_debounce #(
  parameter int unsigned N           = 4,
  parameter int unsigned DB_CYCLES   = 100000,
  parameter int unsigned LONG_CYCLES = 20000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] held,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,  // release event; "release" is a reserved word
  output logic [N-1:0] long_press,
  output logic         any_press
);

  localparam int unsigned   CW     = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DbLast = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
    $error("btn_debounce: illegal DB_CYCLES/LONG_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StWaitP, StPressed, StWaitR} state_e;

  logic [N-1:0]  sync1_q, sync2_q;
  state_e        st_q  [N];
  state_e        st_d  [N];
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  held_q, held_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  rel_q, rel_d;
  logic          any_press_q, any_press_d;

  always_comb begin
    press_d = '0;
    rel_d   = '0;
    held_d  = '0;
    for (int i = 0; i < N; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        StIdle: begin
          if (sync2_q[i]) begin
            st_d[i]  = StWaitP;
            cnt_d[i] = '0;
          end
        end
        StWaitP: begin
          if (!sync2_q[i]) begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DbLast) begin
            st_d[i]    = StPressed;
            cnt_d[i]   = '0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        StPressed: begin
          if (!sync2_q[i]) begin
            st_d[i]  = StWaitR;
            cnt_d[i] = '0;
          end
        end
        StWaitR: begin
          if (sync2_q[i]) begin
            st_d[i]  = StPressed;
            cnt_d[i] = '0;
          end else if (cnt_q[i] == DbLast) begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
            rel_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          st_d[i]  = StIdle;
          cnt_d[i] = '0;
        end
      endcase
      // held follows the next state so it moves on the same edge as the transition
      held_d[i] = (st_d[i] == StPressed) || (st_d[i] == StWaitR);
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      held_q      <= '0;
      press_q     <= '0;
      rel_q       <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      held_q      <= held_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < N; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign held          = held_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign any_press     = any_press_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned   LW       = $clog2(LONG_CYCLES);
  localparam logic [LW-1:0] LongLast = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] long_cnt_q [N];
  logic [LW-1:0] long_cnt_d [N];
  logic [N-1:0]  long_done_q, long_done_d;
  logic [N-1:0]  long_q, long_d;

  always_comb begin
    long_done_d = long_done_q;
    long_d      = '0;
    for (int i = 0; i < N; i++) begin
      long_cnt_d[i] = long_cnt_q[i];
      if (st_d[i] == StIdle || (st_q[i] == StWaitP && st_d[i] == StPressed)) begin
        long_cnt_d[i]  = '0;
        long_done_d[i] = 1'b0;
      end else if (st_q[i] == StPressed || st_q[i] == StWaitR) begin
        // count saturates at the last value; the done flag limits it to one pulse per hold
        if (long_cnt_q[i] != LongLast) begin
          long_cnt_d[i] = long_cnt_q[i] + LW'(1);
        end else if (!long_done_q[i]) begin
          long_d[i]      = 1'b1;
          long_done_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_done_q <= '0;
      long_q      <= '0;
      for (int i = 0; i < N; i++) begin
        long_cnt_q[i] <= '0;
      end
    end else begin
      long_done_q <= long_done_d;
      long_q      <= long_d;
      for (int i = 0; i < N; i++) begin
        long_cnt_q[i] <= long_cnt_d[i];
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce (DB_CYCLES=4, LONG_CYCLES=20); honours BTN_DEBOUNCE_LONG_PRESS_EN.
module tb_btn_debounce;

  localparam int LongCycles = 20;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] held;
  logic [3:0] press;
  logic [3:0] release_pulse;
  logic [3:0] long_press;
  logic       any_press;

  btn_debounce #(
    .N          (4),
    .DB_CYCLES  (4),
    .LONG_CYCLES(LongCycles)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .held         (held),
    .press        (press),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .any_press    (any_press)
  );

  typedef struct {
    int         edge_n;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] held;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         lp_exp [4];
  logic [3:0] held_exp;
  int         cyc;
  int         n_checks;
  int         n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_press(input logic [3:0] mask, input int p_edge);
    held_exp = held_exp | mask;
    exp_q.push_back('{p_edge, mask, 4'b0, held_exp});
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    for (int c = 0; c < 4; c++) if (mask[c]) lp_exp[c] = p_edge + LongCycles;
`endif
  endtask

  task automatic push_release(input logic [3:0] mask, input int r_edge);
    held_exp = held_exp & ~mask;
    exp_q.push_back('{r_edge, 4'b0, mask, held_exp});
    // a release landing on or before the long-press edge suppresses it
    for (int c = 0; c < 4; c++) if (mask[c] && lp_exp[c] >= 0 && r_edge <= lp_exp[c]) lp_exp[c] = -1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if ((press | release_pulse) != 4'b0 || any_press) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({any_press, press, release_pulse}), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("event_cycle", cyc, mon_e.edge_n);
          check("press", 32'(press), 32'(mon_e.press));
          check("release", 32'(release_pulse), 32'(mon_e.rel));
          check("held_at_event", 32'(held), 32'(mon_e.held));
          check("any_press", 32'(any_press), 32'(|mon_e.press));
        end
      end else if (exp_q.size() != 0 && exp_q[0].edge_n < cyc) begin
        mon_e = exp_q.pop_front();
        check("missed_event", cyc, mon_e.edge_n);
      end
      for (int c = 0; c < 4; c++) begin
        if (cyc == lp_exp[c]) begin
          check("long_press_fire", 32'(long_press[c]), 32'(1));
          lp_exp[c] = -1;
        end else if (long_press[c]) begin
          check("long_press_unexpected", 32'(long_press[c]), 32'(0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    int t;
    int p;
    int pend;
    n_checks = 0;
    n_pass   = 0;
    held_exp = 4'b0;
    for (int c = 0; c < 4; c++) lp_exp[c] = -1;
    reset  = 1'b1;
    btn_in = 4'b0;
    tick(3);
    check("rst_held", 32'(held), 32'(0));
    check("rst_press", 32'(press), 32'(0));
    check("rst_release", 32'(release_pulse), 32'(0));
    check("rst_long", 32'(long_press), 32'(0));
    check("rst_any", 32'(any_press), 32'(0));
    reset = 1'b0;
    tick(3);

    // clean press on channel 0
    s = cyc + 1;
    btn_in = 4'b0001;
    push_press(4'b0001, s + 6);
    tick(6);
    check("t1_held_early", 32'(held), 32'(0));
    tick(1);
    check("t1_held_set", 32'(held), 32'(4'b0001));
    tick(1);
    check("t1_press_one_cycle", 32'(press), 32'(0));
    tick(2);

    // bounce on channel 1: 3 high, 2 low, then stable high
    s = cyc + 1;
    btn_in = 4'b0011;
    tick(3);
    btn_in = 4'b0001;
    tick(2);
    btn_in = 4'b0011;
    push_press(4'b0010, s + 11);
    tick(6);
    check("t2_held_bounce", 32'(held[1]), 32'(0));
    tick(3);

    // release with bounce on channel 0: 2 low, 1 high, then stable low
    s = cyc + 1;
    btn_in = 4'b0010;
    tick(2);
    btn_in = 4'b0011;
    tick(1);
    btn_in = 4'b0010;
    push_release(4'b0001, s + 9);
    tick(6);
    check("t3_held_bounce", 32'(held[0]), 32'(1));
    tick(3);

    s = cyc + 1;
    btn_in = 4'b0000;
    push_release(4'b0010, s + 6);
    tick(10);

    // all channels together
    s = cyc + 1;
    btn_in = 4'b1111;
    push_press(4'b1111, s + 6);
    tick(12);
    check("t4_held_all", 32'(held), 32'(4'b1111));
    s = cyc + 1;
    btn_in = 4'b0000;
    push_release(4'b1111, s + 6);
    tick(10);
    check("t4_held_none", 32'(held), 32'(0));

    // reset while channel 2 counts in WAIT_P and channel 3 is held
    s = cyc + 1;
    btn_in = 4'b1000;
    push_press(4'b1000, s + 6);
    tick(8);
    check("t5_q_empty", exp_q.size(), 0);
    btn_in = 4'b1100;
    tick(5);
    reset = 1'b1;
    held_exp = 4'b0;
    for (int c = 0; c < 4; c++) lp_exp[c] = -1;
    #1;
    check("t5_rst_held", 32'(held), 32'(0));
    check("t5_rst_press", 32'(press), 32'(0));
    check("t5_rst_release", 32'(release_pulse), 32'(0));
    check("t5_rst_any", 32'(any_press), 32'(0));
    tick(2);
    reset = 1'b0;
    t = cyc;
    push_press(4'b1100, t + 7);
    tick(6);
    check("t5_held_latency", 32'(held), 32'(0));
    tick(3);
    s = cyc + 1;
    btn_in = 4'b0000;
    push_release(4'b1100, s + 6);
    tick(10);

    // long hold on channel 0 with a 2-cycle low bounce mid-hold
    s = cyc + 1;
    p = s + 6;
    btn_in = 4'b0001;
    push_press(4'b0001, p);
    tick(14);
    btn_in = 4'b0000;
    tick(2);
    btn_in = 4'b0001;
    tick(2);
    check("t6_held_bounce", 32'(held[0]), 32'(1));
    tick(9);
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    check("t6_long_edge", 32'(long_press[0]), 32'(1));
`else
    check("t6_long_edge", 32'(long_press[0]), 32'(0));
`endif
    tick(1);
    check("t6_long_after", 32'(long_press[0]), 32'(0));
    tick(13);
    btn_in = 4'b0000;
    push_release(4'b0001, cyc + 7);
    tick(10);

    check("final_q_empty", exp_q.size(), 0);
    pend = 0;
    for (int c = 0; c < 4; c++) if (lp_exp[c] >= 0) pend++;
    check("final_long_pending", pend, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
